booth_mult_seq_32: RTL and testbench

- Sequential radix-2 Booth multiplier for signed two's-complement operands. Produces a 2*WIDTH-bit product after WIDTH iteration cycles.
- Sits downstream of the 32-bit add/subtract datapath. Each iteration drives one add_sub_32 instance (mode 0 = add, mode 1 = subtract) and consumes its Result/CarryOut.
- Serves as the MUL execution unit of the processor datapath, with a start/busy/done handshake toward the control unit.

---
 rtl/mul_pkg.sv | 28 ++
 rtl/add_sub_32.sv | 15 +
 rtl/booth_step_32.sv | 51 +++++
 rtl/booth_mult_seq_32.sv | 94 +++++++++
 tb/tb_booth_mult_seq_32.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and defaults for the sequential Booth multiplier
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_e;

  // Radix-2 Booth recoding of the {Q[0], q_1} pair.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/add_sub_32.sv
// rtl/add_sub_32.sv - 32-bit adder/subtractor, mode 0 = a+b, mode 1 = a-b
module add_sub_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mode,
  output logic [31:0] result,
  output logic        carry_out
);

  logic [31:0] b_eff;

  assign b_eff = mode ? ~b : b;
  assign {carry_out, result} = {1'b0, a} + {1'b0, b_eff} + {32'd0, mode};

endmodule

// File: rtl/booth_step_32.sv
// rtl/booth_step_32.sv - one combinational Booth iteration: add/sub, sign repair, arithmetic shift
module booth_step_32
  import mul_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] q_i,
  input  logic        q_1_i,
  input  logic [31:0] m_i,
  output logic [31:0] a_next_o,
  output logic [31:0] q_next_o,
  output logic        q_1_next_o
);

  booth_op_e   op;
  logic        mode;
  logic [31:0] sum;
  logic        cout;
  logic        b_msb;
  logic        ovf;
  logic [31:0] s;
  logic        true_sign;

  assign op   = booth_decode(q_i[0], q_1_i);
  assign mode = (op == OP_SUB);

  add_sub_32 u_add_sub (
    .a        (a_i),
    .b        (m_i),
    .mode     (mode),
    .result   (sum),
    .carry_out(cout)
  );

  // Carry into the MSB differs from the carry out exactly when the signed sum overflowed.
  assign b_msb = mode ? ~m_i[31] : m_i[31];
  assign ovf   = (sum[31] ^ a_i[31] ^ b_msb) ^ cout;

  always_comb begin
    s         = a_i;
    true_sign = a_i[31];
    if (op != OP_NOP) begin
      s         = sum;
      true_sign = sum[31] ^ ovf;
    end
  end

  assign a_next_o   = {true_sign, s[31:1]};
  assign q_next_o   = {s[0], q_i[31:1]};
  assign q_1_next_o = q_i[0];

endmodule

// File: rtl/booth_mult_seq_32.sv
// rtl/booth_mult_seq_32.sv - sequential radix-2 Booth multiplier with start/busy/done handshake
module booth_mult_seq_32
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     a_q, q_q, m_q;
  logic                 q1_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q, done_q;

  logic [WIDTH-1:0]     a_d, q_d;
  logic                 q1_d;

  booth_step_32 u_step (
    .a_i       (a_q),
    .q_i       (q_q),
    .q_1_i     (q1_q),
    .m_i       (m_q),
    .a_next_o  (a_d),
    .q_next_o  (q_d),
    .q_1_next_o(q1_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= '0;
            q_q     <= multiplier;
            q1_q    <= 1'b0;
            m_q     <= multiplicand;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + 1'b1;
          // The final iteration's result goes straight into product on the same edge.
          if (cnt_q == LAST_ITER) begin
            product_q <= {a_d, q_d};
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq_32.sv
// tb/tb_booth_mult_seq_32.sv - self-checking bench for booth_mult_seq_32
module tb_booth_mult_seq_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  booth_mult_seq_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .multiplicand(mcand),
    .multiplier  (mplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: a request accepted while idle yields its product
  // 32 edges later, busy spans the 33 cycles after acceptance.
  int          age;
  logic [63:0] pend;
  logic        m_busy, m_done;
  logic [63:0] m_prod;

  always @(posedge clk) begin
    if (!rst_n) begin
      age <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_prod <= '0;
    end else if (age == 0) begin
      m_done <= 1'b0;
      if (start) begin
        pend   <= smul(mcand, mplier);
        age    <= 1;
        m_busy <= 1'b1;
      end
    end else if (age == 33) begin
      age <= 0; m_busy <= 1'b0; m_done <= 1'b0;
    end else begin
      age <= age + 1;
      if (age == 32) begin
        m_done <= 1'b1;
        m_prod <= pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_vs_model", {63'd0, busy}, {63'd0, m_busy});
      check("done_vs_model", {63'd0, done}, {63'd0, m_done});
      check("product_vs_model", product, m_prod);
    end
  end

  logic [63:0] prev_exp;

  task automatic do_op(input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp, input logic pulses);
    int n, done_at, done_cnt, busy_n;
    logic finished;
    @(posedge clk); #1;
    mcand = m; mplier = q; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    n = 0; done_at = 0; done_cnt = 0; busy_n = 0; finished = 1'b0;
    while (n < 100 && !finished) begin
      @(negedge clk);
      n++;
      if (pulses && (n == 5 || n == 20)) begin
        start = 1'b1; mcand = $urandom; mplier = $urandom;
      end else begin
        start = 1'b0;
      end
      if (n == 16) check("product_held", product, prev_exp);
      if (busy) busy_n++;
      if (done) begin
        done_cnt++;
        done_at = n;
        check("product_literal", product, exp);
      end
      if (!busy) finished = 1'b1;
    end
    start = 1'b0;
    if (!finished) check("op_timeout", 64'd0, 64'd1);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("done_latency_edges", 64'(done_at - 1), 64'd32);
    check("busy_cycles", 64'(busy_n), 64'd33);
    prev_exp = exp;
  endtask

  initial begin
    logic [31:0] rm, rq;
    int dc;
    rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0; prev_exp = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);

    do_op(32'd3, 32'd5, 64'd15, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    do_op(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
    do_op(32'd0, 32'h1234_5678, 64'd0, 1'b0);
    do_op(32'd2, 32'd9, 64'd18, 1'b1);

    // Abort an operation with a one-edge reset at cycle 10.
    @(posedge clk); #1;
    mcand = $urandom; mplier = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_product", product, 64'd0);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("abort_no_done", 64'(dc), 64'd0);
    prev_exp = '0;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i == 3) rm = 32'h8000_0000;
      if (i == 6) rq = 32'h8000_0000;
      if (i == 8) rm = 32'h7FFF_FFFF;
      do_op(rm, rq, smul(rm, rq), 1'b0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
